// File: rtl/axi_rd_burst_seq.sv
// Splits a word-count read request into AXI-legal bursts (no 4 KB crossing) and streams the data.
// Define AXI_RD_BURST_SEQ_ERR_ABORT_EN to abandon the sequence on an errored burst.
module axi_rd_burst_seq #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [COUNT_WIDTH-1:0]             num_words,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic                               rd_enable,
  output logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic [3:0]                         rd_burst_len,
  output logic [2:0]                         rd_burst_size,
  input  logic [MAX_BURST_LEN*BUS_WIDTH-1:0] rd_data,
  input  logic [1:0]                         rd_status,
  output logic [BUS_WIDTH-1:0]               out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last
);

  localparam int unsigned SizeInt = $clog2(BUS_WIDTH / 8);
  localparam logic [2:0]  Size    = 3'(SizeInt);

  localparam logic [1:0] StatReady = 2'd0;
  localparam logic [1:0] StatOk    = 2'd2;
  localparam logic [1:0] StatErr   = 2'd3;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StDone} state_e;

  state_e                             state_q, state_d;
  logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]             remaining_q, remaining_d;
  logic [3:0]                         len_q, len_d;
  logic [3:0]                         idx_q, idx_d;
  logic                               error_q, error_d;
  logic [MAX_BURST_LEN*BUS_WIDTH-1:0] burst_buf_q, burst_buf_d;

  logic [ADDR_WIDTH-1:0]  next_addr;
  logic [COUNT_WIDTH-1:0] next_rem;
  logic [4:0]             n_words;

  // Burst size limited by remaining count, MAX_BURST_LEN and the distance to the next 4 KB page.
  function automatic logic [4:0] burst_words(input logic [11:0] page_off,
                                             input logic [COUNT_WIDTH-1:0] rem);
    logic [12:0] to_bnd_bytes;
    logic [12:0] to_bnd_words;
    logic [4:0]  n;
    to_bnd_bytes = 13'h1000 - {1'b0, page_off};
    to_bnd_words = to_bnd_bytes >> Size;
    n = 5'(MAX_BURST_LEN);
    if (to_bnd_words < 13'(n)) n = to_bnd_words[4:0];
    if (rem < COUNT_WIDTH'(n)) n = rem[4:0];
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    idx_d       = idx_q;
    error_d     = error_q;
    burst_buf_d = burst_buf_q;
    n_words     = 5'd0;
    next_addr   = addr_q + (ADDR_WIDTH'({1'b0, len_q} + 5'd1) << Size);
    next_rem    = remaining_q - COUNT_WIDTH'({1'b0, len_q} + 5'd1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          error_d = 1'b0;
          if (num_words == '0) begin
            state_d = StDone;
          end else begin
            addr_d      = base_addr;
            remaining_d = num_words;
            n_words     = burst_words(base_addr[11:0], num_words);
            len_d       = 4'(n_words - 5'd1);
            idx_d       = 4'd0;
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        if (rd_status == StatReady) state_d = StWait;
      end
      StWait: begin
        if (rd_status == StatOk) begin
          burst_buf_d = rd_data;
          state_d     = StDrain;
        end else if (rd_status == StatErr) begin
          error_d = 1'b1;
`ifdef AXI_RD_BURST_SEQ_ERR_ABORT_EN
          state_d = StDone;
`else
          burst_buf_d = rd_data;
          state_d     = StDrain;
`endif
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (idx_q == len_q) begin
            addr_d      = next_addr;
            remaining_d = next_rem;
            idx_d       = 4'd0;
            if (next_rem == '0) begin
              state_d = StDone;
            end else begin
              n_words = burst_words(next_addr[11:0], next_rem);
              len_d   = 4'(n_words - 5'd1);
              state_d = StReq;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      error_q     <= 1'b0;
      burst_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      error_q     <= error_d;
      burst_buf_q <= burst_buf_d;
    end
  end

  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    error         = error_q;
    rd_enable     = (state_q == StReq) && (rd_status == StatReady);
    rd_addr       = addr_q;
    rd_burst_len  = len_q;
    rd_burst_size = Size;
    out_valid     = (state_q == StDrain);
    out_data      = burst_buf_q[idx_q*BUS_WIDTH +: BUS_WIDTH];
    out_last      = out_valid && (idx_q == len_q) && (next_rem == '0);
  end

endmodule

// File: tb/tb_axi_rd_burst_seq.sv
// Directed bench for axi_rd_burst_seq with a behavioural read helper that returns word i of a
// burst as (burst address + 4*i), so the expected stream is simply base + 4*k.
module tb_axi_rd_burst_seq;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 32;
  localparam int unsigned ML = 16;
  localparam int unsigned CW = 16;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [CW-1:0]  num_words;
  logic           busy, done, error, rd_enable;
  logic [AW-1:0]  rd_addr;
  logic [3:0]     rd_burst_len;
  logic [2:0]     rd_burst_size;
  logic [ML*BW-1:0] rd_data;
  logic [1:0]     rd_status;
  logic [BW-1:0]  out_data;
  logic           out_valid, out_ready, out_last;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int err_burst = -1;
  int done_cnt  = 0;

  logic [AW-1:0] log_addr[$];
  logic [3:0]    log_len[$];
  logic [BW-1:0] words[$];
  int            last_idx[$];

  axi_rd_burst_seq #(
    .ADDR_WIDTH   (AW),
    .BUS_WIDTH    (BW),
    .MAX_BURST_LEN(ML),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .rd_enable    (rd_enable),
    .rd_addr      (rd_addr),
    .rd_burst_len (rd_burst_len),
    .rd_burst_size(rd_burst_size),
    .rd_data      (rd_data),
    .rd_status    (rd_status),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  always #5 clock = ~clock;

  // Read helper: wait status for two cycles, then one ok/error cycle carrying the burst data.
  initial begin
    logic [AW-1:0] a;
    int idx;
    rd_status = 2'd0;
    rd_data   = '0;
    forever begin
      @(negedge clock);
      if (rd_enable === 1'b1) begin
        a   = rd_addr;
        idx = log_addr.size();
        log_addr.push_back(rd_addr);
        log_len.push_back(rd_burst_len);
        @(posedge clock); #1;
        rd_status = 2'd1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        for (int i = 0; i < ML; i++) rd_data[i*BW +: BW] = a + AW'(4 * i);
        rd_status = (idx == err_burst) ? 2'd3 : 2'd2;
        @(posedge clock); #1;
        rd_status = 2'd0;
      end
    end
  end

  always @(negedge clock) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      words.push_back(out_data);
      if (out_last === 1'b1) last_idx.push_back(words.size() - 1);
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    words.delete();
    last_idx.delete();
    log_addr.delete();
    log_len.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [CW-1:0] n);
    @(posedge clock); #1;
    base_addr = a;
    num_words = n;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
    @(posedge clock); #1;
  endtask

  task automatic check_seq(input string tag, input logic [AW-1:0] base, input int n);
    check({tag, " word_count"}, 64'(words.size()), 64'(n));
    for (int k = 0; k < n && k < words.size(); k++)
      check({tag, " word"}, 64'(words[k]), 64'(base + AW'(4 * k)));
    check({tag, " last_count"}, 64'(last_idx.size()), 64'd1);
    if (last_idx.size() > 0) check({tag, " last_pos"}, 64'(last_idx[0]), 64'(n - 1));
  endtask

  initial begin
    logic seen;
    reset_n   = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    out_ready = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst error", 64'(error), 64'd0);
    check("rst rd_enable", 64'(rd_enable), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_last", 64'(out_last), 64'd0);
    check("rst rd_addr", 64'(rd_addr), 64'd0);
    check("rst rd_burst_len", 64'(rd_burst_len), 64'd0);
    check("burst_size", 64'(rd_burst_size), 64'd2);
    reset_n = 1'b1;

    // 20 words from 0x1000: 16 + 4 split, with start/data latency checks
    clear_logs();
    @(posedge clock); #1;
    base_addr = 32'h1000;
    num_words = 16'd20;
    start     = 1'b1;
    @(negedge clock);
    check("t1 rd_enable in start cycle", 64'(rd_enable), 64'd0);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("t1 rd_enable at N+1", 64'(rd_enable), 64'd1);
    check("t1 busy", 64'(busy), 64'd1);
    check("t1 rd_addr", 64'(rd_addr), 64'h1000);
    check("t1 rd_burst_len", 64'(rd_burst_len), 64'd15);
    repeat (3) @(negedge clock);
    check("t1 out_valid in status cycle", 64'(out_valid), 64'd0);
    @(negedge clock);
    check("t1 out_valid after status", 64'(out_valid), 64'd1);
    check("t1 first out_data", 64'(out_data), 64'h1000);
    wait_done("t1 done", 300);
    check("t1 bursts", 64'(log_addr.size()), 64'd2);
    check("t1 burst0 addr", 64'(log_addr[0]), 64'h1000);
    check("t1 burst0 len", 64'(log_len[0]), 64'd15);
    check("t1 burst1 addr", 64'(log_addr[1]), 64'h1040);
    check("t1 burst1 len", 64'(log_len[1]), 64'd3);
    check_seq("t1", 32'h1000, 20);
    check("t1 done pulses", 64'(done_cnt), 64'd1);
    check("t1 error", 64'(error), 64'd0);
    check("t1 busy after", 64'(busy), 64'd0);

    // 4 KB boundary split
    clear_logs();
    pulse_start(32'h0FF8, 16'd4);
    wait_done("t2 done", 200);
    check("t2 bursts", 64'(log_addr.size()), 64'd2);
    check("t2 burst0 addr", 64'(log_addr[0]), 64'h0FF8);
    check("t2 burst0 len", 64'(log_len[0]), 64'd1);
    check("t2 burst1 addr", 64'(log_addr[1]), 64'h1000);
    check("t2 burst1 len", 64'(log_len[1]), 64'd1);
    check_seq("t2", 32'h0FF8, 4);

    // Zero-length request
    clear_logs();
    @(posedge clock); #1;
    base_addr = 32'h2000;
    num_words = 16'd0;
    start     = 1'b1;
    @(negedge clock);
    check("t3 done in start cycle", 64'(done), 64'd0);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("t3 done at N+1", 64'(done), 64'd1);
    check("t3 busy at N+1", 64'(busy), 64'd1);
    @(negedge clock);
    check("t3 done at N+2", 64'(done), 64'd0);
    check("t3 busy at N+2", 64'(busy), 64'd0);
    repeat (4) @(negedge clock);
    check("t3 no rd_enable", 64'(log_addr.size()), 64'd0);

    // Consumer stall for 5 cycles mid-burst
    clear_logs();
    pulse_start(32'h3000, 16'd20);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("t4 first word seen", 64'(seen), 64'd1);
    @(posedge clock); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t4 stall out_valid", 64'(out_valid), 64'd1);
      check("t4 stall out_data", 64'(out_data), 64'h3004);
      check("t4 stall rd_enable", 64'(rd_enable), 64'd0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    wait_done("t4 done", 300);
    check("t4 bursts", 64'(log_addr.size()), 64'd2);
    check_seq("t4", 32'h3000, 20);

    // Second burst errors
    clear_logs();
    err_burst = 1;
    pulse_start(32'h1000, 16'd20);
    wait_done("t5 done", 300);
    err_burst = -1;
`ifdef AXI_RD_BURST_SEQ_ERR_ABORT_EN
    check("t5 word_count", 64'(words.size()), 64'd16);
    check("t5 last_count", 64'(last_idx.size()), 64'd0);
`else
    check_seq("t5", 32'h1000, 20);
`endif
    check("t5 error", 64'(error), 64'd1);
    check("t5 done pulses", 64'(done_cnt), 64'd1);

    // Reset while waiting on the helper, then a clean sequence
    clear_logs();
    @(posedge clock); #1;
    base_addr = 32'h4000;
    num_words = 16'd4;
    start     = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("t6 error cleared by start", 64'(error), 64'd0);
    check("t6 rd_enable", 64'(rd_enable), 64'd1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("t6 rst busy", 64'(busy), 64'd0);
    check("t6 rst rd_enable", 64'(rd_enable), 64'd0);
    check("t6 rst rd_addr", 64'(rd_addr), 64'd0);
    check("t6 rst rd_burst_len", 64'(rd_burst_len), 64'd0);
    check("t6 rst out_valid", 64'(out_valid), 64'd0);
    check("t6 rst done", 64'(done), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("t6 no done after reset", 64'(done_cnt), 64'd0);
    check("t6 no words after reset", 64'(words.size()), 64'd0);
    clear_logs();
    pulse_start(32'h5000, 16'd3);
    wait_done("t6 clean done", 200);
    check("t6 bursts", 64'(log_addr.size()), 64'd1);
    check("t6 burst0 addr", 64'(log_addr[0]), 64'h5000);
    check("t6 burst0 len", 64'(log_len[0]), 64'd2);
    check_seq("t6", 32'h5000, 3);
    check("t6 error", 64'(error), 64'd0);
    check("t6 done pulses", 64'(done_cnt), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
